// File: rtl/pulp_sync_filter_pkg.sv
// Shared types and helpers for the synchronising glitch filter.
package pulp_sync_filter_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } filter_state_e;

  function automatic int cnt_width(int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pulp_sync_chain.sv
// Plain multi-flop synchroniser; kept standalone so it can be swapped for a hardened cell.
module pulp_sync_chain
  import pulp_sync_filter_pkg::*;
#(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("pulp_sync_chain: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulp_sync_filter.sv
// Synchronises an asynchronous bit, qualifies changes over FILTER_CYCLES enabled
// cycles, and emits a registered level plus rise/fall/glitch event pulses.
module pulp_sync_filter
  import pulp_sync_filter_pkg::*;
#(
  parameter int unsigned STAGES        = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_VALUE   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          sync;
  filter_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic          glitch_q;

  pulp_sync_chain #(
    .STAGES      (STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_chain (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (async_i),
    .q_o   (sync)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      level_q  <= RESET_VALUE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      unique case (state_q)
        STABLE: begin
          if ((sync != level_q) && en_i) begin
            // A one-cycle window needs no pending phase: accept immediately.
            if (FILTER_CYCLES == 1) begin
              level_q <= sync;
              rise_q  <= sync;
              fall_q  <= ~sync;
            end else begin
              cnt_q   <= CNT_ONE;
              state_q <= PENDING;
            end
          end
        end
        PENDING: begin
          if (sync == level_q) begin
            cnt_q    <= '0;
            glitch_q <= 1'b1;
            state_q  <= STABLE;
          end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
              level_q <= sync;
              rise_q  <= sync;
              fall_q  <= ~sync;
              cnt_q   <= '0;
              state_q <= STABLE;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= STABLE;
        end
      endcase
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign glitch_o = glitch_q;

endmodule

// File: tb/tb_pulp_sync_filter.sv
// Directed bench for pulp_sync_filter: default filter instance plus a FILTER_CYCLES=1, RESET_VALUE=1 instance.
module tb_pulp_sync_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic en_a = 1'b1, async_a = 1'b0;
  logic level_a, rise_a, fall_a, glitch_a;

  logic en_b = 1'b1, async_b = 1'b1;
  logic level_b, rise_b, fall_b, glitch_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulp_sync_filter #(
    .STAGES        (2),
    .FILTER_CYCLES (4),
    .RESET_VALUE   (1'b0)
  ) dut_a (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en_a),
    .async_i  (async_a),
    .level_o  (level_a),
    .rise_o   (rise_a),
    .fall_o   (fall_a),
    .glitch_o (glitch_a)
  );

  pulp_sync_filter #(
    .STAGES        (2),
    .FILTER_CYCLES (1),
    .RESET_VALUE   (1'b1)
  ) dut_b (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en_b),
    .async_i  (async_b),
    .level_o  (level_b),
    .rise_o   (rise_b),
    .fall_o   (fall_b),
    .glitch_o (glitch_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({level_a, rise_a, fall_a, glitch_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_a: got lvl/r/f/g=%b required 0000", {level_a, rise_a, fall_a, glitch_a});
    end
    checks++;
    if ({level_b, rise_b, fall_b, glitch_b} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_b: got lvl/r/f/g=%b required 1000", {level_b, rise_b, fall_b, glitch_b});
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({level_a, rise_a, fall_a, glitch_a} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: got %b required 0000", i, {level_a, rise_a, fall_a, glitch_a});
      end
    end
  endtask

  task automatic restore_a();
    async_a = 1'b0;
    en_a    = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (level_a !== 1'b0) begin
      errors++;
      $display("FAIL restore_level: got %b required 0", level_a);
    end
  endtask

  task automatic test_clean_rise();
    logic exp_lvl, exp_rise;
    en_a    = 1'b1;
    async_a = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      checks++;
      if ({level_a, rise_a, fall_a, glitch_a} !== {exp_lvl, exp_rise, 2'b00}) begin
        errors++;
        $display("FAIL clean_rise cyc %0d: got %b required %b", i,
                 {level_a, rise_a, fall_a, glitch_a}, {exp_lvl, exp_rise, 2'b00});
      end
    end
    restore_a();
  endtask

  task automatic test_glitch();
    int n_glitch = 0;
    int n_rise   = 0;
    async_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) async_a = 1'b0;
      n_glitch += int'(glitch_a);
      n_rise   += int'(rise_a);
      checks++;
      if (glitch_a !== (i == 6)) begin
        errors++;
        $display("FAIL glitch_pulse cyc %0d: got %b required %b", i, glitch_a, (i == 6));
      end
      checks++;
      if (level_a !== 1'b0) begin
        errors++;
        $display("FAIL glitch_level cyc %0d: got %b required 0", i, level_a);
      end
    end
    checks++;
    if (n_glitch != 1 || n_rise != 0) begin
      errors++;
      $display("FAIL glitch_count: got glitch=%0d rise=%0d required 1/0", n_glitch, n_rise);
    end
  endtask

  task automatic test_enable_stall();
    logic exp_lvl, exp_rise;
    async_a = 1'b1;
    en_a    = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 7) en_a = 1'b1;
      exp_lvl  = (i >= 11);
      exp_rise = (i == 11);
      checks++;
      if ({level_a, rise_a, fall_a, glitch_a} !== {exp_lvl, exp_rise, 2'b00}) begin
        errors++;
        $display("FAIL enable_stall cyc %0d: got %b required %b", i,
                 {level_a, rise_a, fall_a, glitch_a}, {exp_lvl, exp_rise, 2'b00});
      end
    end
    restore_a();
  endtask

  task automatic test_reset_pending();
    logic exp_lvl, exp_rise;
    async_a = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({level_a, rise_a, fall_a, glitch_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pending: got %b required 0000", {level_a, rise_a, fall_a, glitch_a});
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      checks++;
      if ({level_a, rise_a, fall_a, glitch_a} !== {exp_lvl, exp_rise, 2'b00}) begin
        errors++;
        $display("FAIL post_reset_rise cyc %0d: got %b required %b", i,
                 {level_a, rise_a, fall_a, glitch_a}, {exp_lvl, exp_rise, 2'b00});
      end
    end
    restore_a();
  endtask

  task automatic test_fc1();
    logic exp_lvl, exp_rise, exp_fall;
    async_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_lvl  = (i < 3);
      exp_fall = (i == 3);
      checks++;
      if ({level_b, rise_b, fall_b, glitch_b} !== {exp_lvl, 1'b0, exp_fall, 1'b0}) begin
        errors++;
        $display("FAIL fc1_fall cyc %0d: got %b required %b", i,
                 {level_b, rise_b, fall_b, glitch_b}, {exp_lvl, 1'b0, exp_fall, 1'b0});
      end
    end
    async_b = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (level_b !== 1'b1) begin
      errors++;
      $display("FAIL fc1_restore: got %b required 1", level_b);
    end
    async_b = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) async_b = 1'b1;
      exp_lvl  = (i != 3);
      exp_fall = (i == 3);
      exp_rise = (i == 4);
      checks++;
      if ({level_b, rise_b, fall_b, glitch_b} !== {exp_lvl, exp_rise, exp_fall, 1'b0}) begin
        errors++;
        $display("FAIL fc1_short_pulse cyc %0d: got %b required %b", i,
                 {level_b, rise_b, fall_b, glitch_b}, {exp_lvl, exp_rise, exp_fall, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_enable_stall();
    test_reset_pending();
    test_fc1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
